// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and constants for the instruction-fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    // Fetch controller states: issuing, waiting for data, holding buffered data
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // Default bubble / flush instruction word
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Sequential PC increment
    localparam int PC_STEP = 4;

endpackage : if_pkg
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ifid_reg
//  Description : IF/ID pipeline register. Update priority is
//                flush > stall > load > bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import if_pkg::*;
#(
    parameter int            N         = 32,
    parameter logic [N-1:0]  NOP_INSTR = N'(NOP_INSTR_DEFAULT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         stall_i,
    input  logic         load_i,
    input  logic [N-1:0] load_instr_i,
    input  logic [N-1:0] load_pc_plus4_i,
    output logic [N-1:0] instr_o,
    output logic [N-1:0] pc_plus4_o,
    output logic         valid_o
);

    logic [N-1:0] instr_q,    instr_d;
    logic [N-1:0] pc_plus4_q, pc_plus4_d;
    logic         valid_q,    valid_d;

    // Next IF/ID contents; a bubble keeps the last fetch address
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (stall_i) begin
            instr_d    = instr_q;
            pc_plus4_d = pc_plus4_q;
            valid_d    = valid_q;
        end else if (load_i) begin
            instr_d    = load_instr_i;
            pc_plus4_d = load_pc_plus4_i;
            valid_d    = 1'b1;
        end else begin
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end
    end

    // IF/ID storage with synchronous reset to an empty bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch controller. Issues one imem read at a time,
//                owns the IF/ID register and drives the PC write-enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int            N         = 32,
    parameter logic [N-1:0]  NOP_INSTR = N'(NOP_INSTR_DEFAULT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_value,
    input  logic         stall,
    input  logic         flush,
    output logic         pc_write,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] ifid_instr,
    output logic [N-1:0] ifid_pc_plus4,
    output logic         ifid_valid
);

    fetch_state_t state_q, state_d;
    logic         drop_q,  drop_d;
    logic [N-1:0] req_pc_q,    req_pc_d;
    logic [N-1:0] buf_instr_q, buf_instr_d;
    logic [N-1:0] buf_pc_q,    buf_pc_d;

    logic         req_raw;
    logic         deliver;
    logic [N-1:0] dl_instr;
    logic [N-1:0] dl_pc;
    logic [N-1:0] dl_pc_plus4;

    // Next-state, request and delivery decode
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        req_pc_d    = req_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        req_raw     = 1'b0;
        deliver     = 1'b0;
        dl_instr    = buf_instr_q;
        dl_pc       = buf_pc_q;
        case (state_q)
            ST_REQ: begin
                // A redirect this cycle means pc_value is stale: do not fetch it
                req_raw = ~flush;
                if (~flush && imem_ready) begin
                    req_pc_d = pc_value;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dl_instr = imem_rdata;
                dl_pc    = req_pc_q;
                if (imem_rvalid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (~stall) begin
                        deliver = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = req_pc_q;
                        state_d     = ST_HOLD;
                    end
                end else if (flush) begin
                    // The response still has to be absorbed before refetching
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_REQ;
                end else if (~stall) begin
                    deliver = 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    // FSM, drop flag, request address and hold buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_REQ;
            drop_q      <= 1'b0;
            req_pc_q    <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            req_pc_q    <= req_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign dl_pc_plus4 = dl_pc + N'(PC_STEP);

    // The PC moves on a delivery or takes the redirect target on a flush
    assign imem_req  = req_raw & ~reset;
    assign imem_addr = pc_value;
    assign pc_write  = ~reset & (deliver | flush);

    ifid_reg #(
        .N         (N),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush),
        .stall_i         (stall),
        .load_i          (deliver),
        .load_instr_i    (dl_instr),
        .load_pc_plus4_i (dl_pc_plus4),
        .instr_o         (ifid_instr),
        .pc_plus4_o      (ifid_pc_plus4),
        .valid_o         (ifid_valid)
    );

endmodule : if_fetch_unit
`default_nettype wire
